// File: rtl/mac_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : mac_accum_stage
// Summary  : Sums runs of LEN MAC results into a saturating accumulator and
//            presents each run total on a valid/ready output port.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accum_stage #(
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 len_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_remaining;
    logic                 r_sat;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic                 r_out_sat;
    logic                 r_len_err;

    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 w_sat_next;
    logic                 w_accept;
    logic                 w_start_ok;
    logic                 w_start_zero;

    // One extra bit of headroom exposes the overflow for clamping.
    assign w_sum        = {1'b0, r_acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
    assign w_acc_next   = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];
    assign w_sat_next   = r_sat | w_sum[ACC_WIDTH];
    assign w_accept     = in_valid && (r_state == ST_ACCUM);
    assign w_start_ok   = start && (len != '0);
    assign w_start_zero = start && (len == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= ST_ACCUM;
                        r_acc       <= '0;
                        r_sat       <= 1'b0;
                        r_remaining <= len;
                    end else if (w_start_zero) begin
                        r_len_err <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc       <= w_acc_next;
                        r_sat       <= w_sat_next;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_acc_next;
                            r_out_sat   <= w_sat_next;
                            r_state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result stays frozen until the consumer takes it; a
                    // qualifying start on the handshake chains the next run.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_start_ok) begin
                            r_state     <= ST_ACCUM;
                            r_acc       <= '0;
                            r_sat       <= 1'b0;
                            r_remaining <= len;
                        end else begin
                            r_state <= ST_IDLE;
                            if (w_start_zero) begin
                                r_len_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_ACCUM);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign len_err   = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accum_stage
// Summary  : Directed self-checking bench for mac_accum_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accum_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [9:0] out_data;
    logic       out_sat;
    logic       out_ready;
    logic       busy;
    logic       len_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_accum_stage #(
        .IN_WIDTH  (8),
        .ACC_WIDTH (10),
        .CNT_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_ready (out_ready),
        .busy      (busy),
        .len_err   (len_err)
    );

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({out_valid, out_sat, in_ready, busy, len_err} !== 5'b0 || out_data !== 10'd0) begin
            failures++;
            $display("FAIL reset: valid=%b sat=%b rdy=%b busy=%b err=%b data=%0d, want all 0",
                     out_valid, out_sat, in_ready, busy, len_err, out_data);
        end
    endtask

    task automatic test_basic_run();
        begin_run(4'd3);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_accum_entry: in_ready=%b busy=%b, want 1 1", in_ready, busy);
        end
        send(8'd10);
        send(8'd20);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_early_valid: out_valid=%b, want 0", out_valid);
        end
        send(8'd30);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd60 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: valid=%b data=%0d sat=%b rdy=%b, want 1 60 0 0",
                     out_valid, out_data, out_sat, in_ready);
        end
        handshake();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 10'd60) begin
            failures++;
            $display("FAIL basic_after_hs: valid=%b busy=%b data=%0d, want 0 0 60",
                     out_valid, busy, out_data);
        end
    endtask

    task automatic test_saturation();
        begin_run(4'd5);
        for (int i = 0; i < 5; i++) send(8'd255);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd1023 || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_result: valid=%b data=%0d sat=%b, want 1 1023 1",
                     out_valid, out_data, out_sat);
        end
        handshake();
        begin_run(4'd2);
        send(8'd1);
        send(8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd3 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_cleared: valid=%b data=%0d sat=%b, want 1 3 0",
                     out_valid, out_data, out_sat);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        begin_run(4'd2);
        send(8'd5);
        send(8'd6);
        in_valid = 1'b1;
        in_data  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 10'd11 || in_ready !== 1'b0 || out_sat !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: valid=%b data=%0d rdy=%b sat=%b, want 1 11 0 0",
                         i, out_valid, out_data, in_ready, out_sat);
            end
            tick();
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 10'd11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_release: valid=%b data=%0d busy=%b, want 0 11 0",
                     out_valid, out_data, busy);
        end
    endtask

    task automatic test_gaps();
        begin_run(4'd3);
        send(8'd1);
        tick();
        send(8'd2);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL gaps_mid: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        send(8'd3);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd6) begin
            failures++;
            $display("FAIL gaps_result: valid=%b data=%0d, want 1 6", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_reset_midrun();
        begin_run(4'd4);
        send(8'd40);
        send(8'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 10'd0) begin
            failures++;
            $display("FAIL midrun_reset: valid=%b busy=%b data=%0d, want 0 0 0",
                     out_valid, busy, out_data);
        end
        begin_run(4'd1);
        send(8'd7);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd7) begin
            failures++;
            $display("FAIL no_residue: valid=%b data=%0d, want 1 7", out_valid, out_data);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        begin_run(4'd0);
        checks++;
        if (len_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len_err_pulse: len_err=%b busy=%b, want 1 0", len_err, busy);
        end
        tick();
        checks++;
        if (len_err !== 1'b0) begin
            failures++;
            $display("FAIL len_err_width: len_err=%b, want 0", len_err);
        end
        begin_run(4'd2);
        send(8'd4);
        begin_run(4'd9);
        send(8'd5);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd9) begin
            failures++;
            $display("FAIL start_in_accum: valid=%b data=%0d, want 1 9", out_valid, out_data);
        end
        out_ready = 1'b0;
        begin_run(4'd3);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL start_in_hold: valid=%b busy=%b rdy=%b, want 1 1 0",
                     out_valid, busy, in_ready);
        end
        out_ready = 1'b1;
        begin_run(4'd1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL chained_start: valid=%b busy=%b rdy=%b, want 0 1 1",
                     out_valid, busy, in_ready);
        end
        send(8'd8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'd8) begin
            failures++;
            $display("FAIL chained_result: valid=%b data=%0d, want 1 8", out_valid, out_data);
        end
        begin_run(4'd0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || len_err !== 1'b1) begin
            failures++;
            $display("FAIL hs_len_zero: valid=%b busy=%b len_err=%b, want 0 0 1",
                     out_valid, busy, len_err);
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        test_reset();
        test_basic_run();
        test_saturation();
        test_backpressure();
        test_gaps();
        test_reset_midrun();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
